// File: rtl/polybius_stream_ctrl.sv
// polybius_stream_ctrl
// Sequential Polybius key-addition engine. A key of up to p_secret_length
// letters is loaded as grid positions, then message bytes are encrypted or
// decrypted one per cycle with a wrapping key index. Key, input and output
// sides use valid/ready handshakes; the result register is a single stage.

module polybius_stream_ctrl #(
    parameter int p_secret_length = 6
) (
    input  logic       i_w_clk,
    input  logic       i_w_rst,
    input  logic       i_w_mode,
    input  logic       i_w_key_valid,
    input  logic [7:0] i_w_key_byte,
    input  logic       i_w_key_last,
    output logic       o_r_key_ready,
    input  logic       i_w_in_valid,
    input  logic [7:0] i_w_in_byte,
    input  logic       i_w_in_last,
    output logic       o_r_in_ready,
    output logic       o_r_out_valid,
    output logic [7:0] o_r_out_byte,
    output logic       o_r_out_last,
    input  logic       i_w_out_ready,
    output logic       o_r_busy,
    output logic       o_r_key_err
);

    localparam int KW = $clog2(p_secret_length + 1);
    localparam int AW = (p_secret_length > 1) ? $clog2(p_secret_length) : 1;
    localparam logic [KW-1:0] KLEN_MAX = KW'(p_secret_length);

    localparam logic [1:0] ST_KEY   = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Grid position (row*10 + col) of a letter, lowercase folded; 0 for non-letters.
    function automatic logic [7:0] f_pos(input logic [7:0] c);
        logic [7:0] u;
        u = ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
        case (u)
            8'h44: f_pos = 8'd11; // D
            8'h41: f_pos = 8'd12; // A
            8'h4E: f_pos = 8'd13; // N
            8'h49: f_pos = 8'd14; // I
            8'h45: f_pos = 8'd15; // E
            8'h4C: f_pos = 8'd21; // L
            8'h42: f_pos = 8'd22; // B
            8'h43: f_pos = 8'd23; // C
            8'h46: f_pos = 8'd24; // F
            8'h47: f_pos = 8'd25; // G
            8'h48: f_pos = 8'd31; // H
            8'h4B: f_pos = 8'd32; // K
            8'h4D: f_pos = 8'd33; // M
            8'h4F: f_pos = 8'd34; // O
            8'h50: f_pos = 8'd35; // P
            8'h51: f_pos = 8'd41; // Q
            8'h52: f_pos = 8'd42; // R
            8'h53: f_pos = 8'd43; // S
            8'h54: f_pos = 8'd44; // T
            8'h55: f_pos = 8'd45; // U
            8'h56: f_pos = 8'd51; // V
            8'h57: f_pos = 8'd52; // W
            8'h58: f_pos = 8'd53; // X
            8'h59: f_pos = 8'd54; // Y
            8'h5A: f_pos = 8'd55; // Z
            default: f_pos = 8'd0;
        endcase
    endfunction

    // Uppercase letter at a valid grid position; other values pass through unchanged.
    function automatic logic [7:0] f_cell(input logic [7:0] t);
        case (t)
            8'd11: f_cell = 8'h44;
            8'd12: f_cell = 8'h41;
            8'd13: f_cell = 8'h4E;
            8'd14: f_cell = 8'h49;
            8'd15: f_cell = 8'h45;
            8'd21: f_cell = 8'h4C;
            8'd22: f_cell = 8'h42;
            8'd23: f_cell = 8'h43;
            8'd24: f_cell = 8'h46;
            8'd25: f_cell = 8'h47;
            8'd31: f_cell = 8'h48;
            8'd32: f_cell = 8'h4B;
            8'd33: f_cell = 8'h4D;
            8'd34: f_cell = 8'h4F;
            8'd35: f_cell = 8'h50;
            8'd41: f_cell = 8'h51;
            8'd42: f_cell = 8'h52;
            8'd43: f_cell = 8'h53;
            8'd44: f_cell = 8'h54;
            8'd45: f_cell = 8'h55;
            8'd51: f_cell = 8'h56;
            8'd52: f_cell = 8'h57;
            8'd53: f_cell = 8'h58;
            8'd54: f_cell = 8'h59;
            8'd55: f_cell = 8'h5A;
            default: f_cell = t;
        endcase
    endfunction

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] klen_q, klen_d;
    logic [KW-1:0] kidx_q, kidx_d;
    logic          mode_q, mode_d;
    logic          err_q, err_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_byte_q, out_byte_d;
    logic          out_last_q, out_last_d;
    logic          busy_q, busy_d;
    logic [7:0]    key_q [p_secret_length];

    logic          key_ready_s, in_ready_s;
    logic          key_fire_s, in_fire_s, out_fire_s;
    logic          key_we_s;
    logic [AW-1:0] key_waddr_s;
    logic [7:0]    key_pos_s;
    logic [KW-1:0] cur_kidx_s, kidx_inc_s, next_kidx_s;
    logic          cur_mode_s;
    logic [7:0]    kval_s, in_pos_s, result_s;

    // Handshake readiness per state; key beats take priority over message beats in IDLE.
    always_comb begin
        key_ready_s = 1'b0;
        in_ready_s  = 1'b0;
        if (i_w_rst) begin
            key_ready_s = 1'b0;
            in_ready_s  = 1'b0;
        end else begin
            case (state_q)
                ST_KEY: begin
                    key_ready_s = 1'b1;
                end
                ST_IDLE: begin
                    key_ready_s = 1'b1;
                    in_ready_s  = !i_w_key_valid;
                end
                ST_RUN: begin
                    in_ready_s = !out_valid_q || i_w_out_ready;
                end
                default: begin
                    key_ready_s = 1'b0;
                    in_ready_s  = 1'b0;
                end
            endcase
        end
    end

    assign key_fire_s = i_w_key_valid && key_ready_s;
    assign in_fire_s  = i_w_in_valid && in_ready_s;
    assign out_fire_s = out_valid_q && i_w_out_ready;
    assign key_pos_s  = f_pos(i_w_key_byte);

    // Letter datapath: the first message byte uses key[0] and the live mode input.
    always_comb begin
        cur_kidx_s = kidx_q;
        cur_mode_s = mode_q;
        if (state_q == ST_IDLE) begin
            cur_kidx_s = {KW{1'b0}};
            cur_mode_s = i_w_mode;
        end else begin
            cur_kidx_s = kidx_q;
            cur_mode_s = mode_q;
        end
        kval_s   = key_q[cur_kidx_s[AW-1:0]];
        in_pos_s = f_pos(i_w_in_byte);
        if (cur_mode_s) begin
            if (in_pos_s != 8'd0) begin
                result_s = in_pos_s + kval_s;
            end else begin
                result_s = i_w_in_byte + kval_s;
            end
        end else begin
            result_s = f_cell(i_w_in_byte - kval_s);
        end
        kidx_inc_s = cur_kidx_s + KW'(1);
        if (kidx_inc_s >= klen_q) begin
            next_kidx_s = {KW{1'b0}};
        end else begin
            next_kidx_s = kidx_inc_s;
        end
    end

    // Controller next state: key loading, message acceptance and result register.
    always_comb begin
        state_d     = state_q;
        klen_d      = klen_q;
        kidx_d      = kidx_q;
        mode_d      = mode_q;
        err_d       = err_q;
        key_we_s    = 1'b0;
        key_waddr_s = {AW{1'b0}};
        out_valid_d = out_valid_q;
        out_byte_d  = out_byte_q;
        out_last_d  = out_last_q;
        if (out_fire_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (in_fire_s) begin
            out_valid_d = 1'b1;
            out_byte_d  = result_s;
            out_last_d  = i_w_in_last;
            kidx_d      = next_kidx_s;
        end else begin
            out_byte_d  = out_byte_q;
        end
        case (state_q)
            ST_KEY: begin
                if (key_fire_s) begin
                    if (klen_q < KLEN_MAX) begin
                        key_we_s    = 1'b1;
                        key_waddr_s = klen_q[AW-1:0];
                        klen_d      = klen_q + KW'(1);
                        if (key_pos_s == 8'd0) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_q;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    if (i_w_key_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_KEY;
                    end
                end else begin
                    state_d = ST_KEY;
                end
            end
            ST_IDLE: begin
                if (key_fire_s) begin
                    key_we_s    = 1'b1;
                    key_waddr_s = {AW{1'b0}};
                    klen_d      = KW'(1);
                    err_d       = (key_pos_s == 8'd0);
                    state_d     = i_w_key_last ? ST_IDLE : ST_KEY;
                end else if (in_fire_s) begin
                    mode_d  = i_w_mode;
                    state_d = i_w_in_last ? ST_DRAIN : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (in_fire_s && i_w_in_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (out_fire_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_KEY;
            end
        endcase
        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN) || out_valid_d;
    end

    // Control and result registers with synchronous reset back to key loading.
    always_ff @(posedge i_w_clk) begin
        if (i_w_rst) begin
            state_q     <= ST_KEY;
            klen_q      <= {KW{1'b0}};
            kidx_q      <= {KW{1'b0}};
            mode_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'd0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            klen_q      <= klen_d;
            kidx_q      <= kidx_d;
            mode_q      <= mode_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    // Key position storage, cleared on reset so a fresh key must be loaded.
    always_ff @(posedge i_w_clk) begin
        if (i_w_rst) begin
            for (int i = 0; i < p_secret_length; i++) begin
                key_q[i] <= 8'd0;
            end
        end else if (key_we_s) begin
            key_q[key_waddr_s] <= key_pos_s;
        end else begin
            key_q <= key_q;
        end
    end

    assign o_r_key_ready = key_ready_s;
    assign o_r_in_ready  = in_ready_s;
    assign o_r_out_valid = out_valid_q;
    assign o_r_out_byte  = out_byte_q;
    assign o_r_out_last  = out_last_q;
    assign o_r_busy      = busy_q;
    assign o_r_key_err   = err_q;

endmodule

// File: doc/polybius_stream_ctrl.md
# polybius_stream_ctrl

Sequential controller that time-multiplexes one letter-wide Polybius key-addition datapath over a byte stream, replacing the fully unrolled combinational cipher for long messages. It loads and stores a key of up to `p_secret_length` letters. It then encrypts or decrypts message bytes one per cycle with a wrapping key index, behind valid/ready handshakes on the key, input and output sides.

## Interface
- `p_secret_length`, default 6: maximum number of key letters stored.
- `i_w_clk` in 1: clock; all state changes on the rising edge.
- `i_w_rst` in 1: synchronous, active-high reset.
- `i_w_mode` in 1: 0 = decrypt, 1 = encrypt. Sampled only on the first message byte.
- `i_w_key_valid`, `i_w_key_byte[7:0]`, `i_w_key_last` in 1/8/1: key beat.
- `o_r_key_ready` out 1: key beat accepted when valid and ready are both high.
- `i_w_in_valid`, `i_w_in_byte[7:0]`, `i_w_in_last` in 1/8/1: message beat.
- `o_r_in_ready` out 1: message beat accepted when valid and ready are both high.
- `o_r_out_valid`, `o_r_out_byte[7:0]`, `o_r_out_last` out 1/8/1: result beat.
- `i_w_out_ready` in 1: sink accepts the result beat.
- `o_r_busy` out 1: high when the state is RUN or DRAIN, or when `o_r_out_valid` is high.
- `o_r_key_err` out 1: sticky flag for a bad key; cleared when a new key load starts.

## Operation
- **Grid:** rows 1..5 = DANIE / LBCFG / HKMOP / QRSTU / VWXYZ. There is no J.
  - pos(letter) = row*10 + col, giving values 11..55.
  - Lowercase is folded to uppercase. A non-letter has pos = 0.
- **Key storage:** key bytes are converted to pos at load time and stored as 8-bit positions. `klen` counts the stored letters.
- **States:** KEY, IDLE, RUN, DRAIN. Reset state is KEY with `klen` = 0.
- **KEY:** `o_r_key_ready` = 1, `o_r_in_ready` = 0.
  - Each accepted beat stores pos at index `klen`, then `klen` increments.
  - pos = 0 sets `o_r_key_err`.
  - A beat accepted when `klen` = `p_secret_length` is discarded and sets `o_r_key_err`.
  - A beat with `i_w_key_last` = 1 goes to IDLE.
- **IDLE:** `o_r_key_ready` = 1, `o_r_in_ready` = !`i_w_key_valid`. Key has priority over message.
  - Key beat: clear `klen` and `o_r_key_err`, store the byte at index 0. Go to KEY, or stay in IDLE if the beat is last.
  - Message beat: latch `i_w_mode`, set `kidx` = 0, process the byte. Go to RUN, or to DRAIN if the beat is last.
- **RUN:** `o_r_key_ready` = 0, `o_r_in_ready` = !`o_r_out_valid` || `i_w_out_ready`.
  - Each accepted byte uses key[`kidx`]. Then `kidx` = (`kidx` == `klen`-1) ? 0 : `kidx`+1.
  - A last beat goes to DRAIN.
- **DRAIN:** both readies are 0. Go to IDLE once the last result beat completes its handshake.
- **Arithmetic** (c = input byte, k = key pos; all 8-bit, mod 256):
  - Encrypt: out = (pos(c) != 0 ? pos(c) : c) + k.
  - Decrypt: t = c - k. If t/10 is in 1..5 and t%10 is in 1..5, out = grid letter (uppercase); otherwise out = t.
- **Known limitation of the scheme, not a bug:** an encrypted non-letter whose ASCII code is a valid grid position (for example space = 32) decrypts to a letter.
- `o_r_out_last` is the registered copy of the accepted `i_w_in_last`.

## Timing
- **Reset values:**
  - While `i_w_rst` is high, `o_r_key_ready` = `o_r_in_ready` = 0.
  - `o_r_out_valid`, `o_r_out_byte`, `o_r_out_last`, `o_r_busy` and `o_r_key_err` are all 0.
  - The cycle after reset deasserts, `o_r_key_ready` = 1.
- **Result register:** single stage. A byte accepted at edge N appears with `o_r_out_valid` = 1 from edge N onward and stays stable until its handshake.
- **Throughput:** 1 byte/cycle while `i_w_out_ready` is held high.
- **Simultaneous handshakes:** an output handshake and an input accept in the same cycle reload the register with no bubble.
- **Backpressure:** while `o_r_out_valid` is high and `i_w_out_ready` is low, `o_r_in_ready` = 0 and the output holds.
- **Mid-operation reset:** drops the in-flight result, clears the key, and returns to KEY; a new key must be loaded.
- **Single-byte message with `klen` = 1:** IDLE goes to DRAIN, then to IDLE the cycle after the output handshake.
- **Key wrap:** `klen` = 1 keeps `kidx` = 0 throughout. `klen` = `p_secret_length` wraps from 5 to 0.

## Test plan
- Key "AB" (positions 12, 22), encrypt "HI" with last on I → out 43, 36; `o_r_out_last` on 36. Then decrypt 43, 36 → "H", "I".
- Key "AB", encrypt "DDD" → 23, 33, 23, confirming key-index wrap. Encrypt lowercase "h" → 43.
- Key "A", encrypt '~' (126) → 138; decrypt 138 → 126.
- Hold `i_w_out_ready` = 0 after the first result → output stable, `o_r_in_ready` = 0, no second byte accepted. Release → both bytes delivered in order.
- Key "A1" → `o_r_key_err` = 1. Reload key "A" from IDLE → `o_r_key_err` clears. Seven key bytes with `p_secret_length` = 6 → `o_r_key_err` = 1 and `klen` = 6.
- Assert `i_w_rst` during RUN with `o_r_out_valid` high → all outputs 0 next cycle, then `o_r_key_ready` = 1 and `o_r_in_ready` = 0.
